// File: rtl/mcc_pkg.sv
// Shared types and constants for the comparator capture block.
package mcc_pkg;

    typedef enum logic [1:0] {
        EDGE_RISE = 2'b00,
        EDGE_FALL = 2'b01,
        EDGE_BOTH = 2'b10,
        EDGE_NONE = 2'b11
    } edge_mode_t;

    typedef enum logic [1:0] {
        CH_IDLE  = 2'b00,
        CH_ARMED = 2'b01,
        CH_DONE  = 2'b10
    } ch_state_t;

    localparam logic [15:0] LED_TEST_PATTERN = 16'h5555;

    // True when a filtered-level change is of the kind selected by mode.
    function automatic logic edge_qualifies(input edge_mode_t mode,
                                            input logic       rise,
                                            input logic       fall);
        logic q;
        case (mode)
            EDGE_RISE: q = rise;
            EDGE_FALL: q = fall;
            EDGE_BOTH: q = rise | fall;
            default:   q = 1'b0;
        endcase
        return q;
    endfunction

endpackage

// File: rtl/comp_chan_filter.sv
// One comparator channel: synchroniser chain, consecutive-sample
// filter and edge detector. rise/fall are registered one-cycle pulses
// issued on the cycle the filtered level changes.
module comp_chan_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic comp_raw,
    output logic rise,
    output logic fall
);

    localparam int             CW     = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam logic [CW-1:0]  RELOAD = CW'(FILT_LEN - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_s;
    logic                   level_q;
    logic [CW-1:0]          cnt_q;
    logic                   rise_q;
    logic                   fall_q;

    assign sync_s = sync_q[SYNC_STAGES-1];
    assign rise   = rise_q;
    assign fall   = fall_q;

    // Synchroniser chain for the asynchronous comparator output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], comp_raw};
        end
    end

    // Down-counter of remaining differing samples; any sample equal to the
    // current level restarts the run, so only FILT_LEN consecutive
    // differing samples move the level. The counter sits at its reload
    // value whenever no run is in progress, including out of reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level_q <= 1'b0;
            cnt_q   <= RELOAD;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            if (sync_s == level_q) begin
                cnt_q <= RELOAD;
            end else if (cnt_q == '0) begin
                level_q <= sync_s;
                cnt_q   <= RELOAD;
                rise_q  <= sync_s;
                fall_q  <= ~sync_s;
            end else begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/mc_comparator_capture.sv
// Multi-channel comparator capture: each channel records the PWM count at
// its first qualified comparator edge in a PWM period.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// CH_IDLE  | after reset; no capture until the next period_start
// CH_ARMED | waiting for a qualified edge in the current period
// CH_DONE  | captured this period; further edges ignored until period_start
module mc_comparator_capture #(
    parameter int N_CH        = 4,
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_CH-1:0]  comp_in,
    input  logic [CNT_W-1:0] pwm_count,
    input  logic             period_start,
    input  logic [1:0]       edge_mode,
    input  logic [2:0]       rd_ch,
    input  logic             rd_ack,
    input  logic             test_force,
    output logic [N_CH-1:0]  capture_en,
    output logic [CNT_W-1:0] sample,
    output logic             sample_valid,
    output logic [N_CH-1:0]  overrun,
    output logic [15:0]      led
);

    import mcc_pkg::*;

    edge_mode_t       mode;
    logic [CNT_W-1:0] result_arr [N_CH];
    logic [N_CH-1:0]  valid_vec;

    assign mode = edge_mode_t'(edge_mode);

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        ch_state_t        state_q;
        ch_state_t        state_d;
        logic             ch_rise;
        logic             ch_fall;
        logic             qual;
        logic             ack_hit;
        logic             cap_d;
        logic             cap_q;
        logic             valid_q;
        logic             overrun_q;
        logic [CNT_W-1:0] result_q;

        comp_chan_filter #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILT_LEN    (FILT_LEN)
        ) u_filt (
            .clk      (clk),
            .reset    (reset),
            .comp_raw (comp_in[g]),
            .rise     (ch_rise),
            .fall     (ch_fall)
        );

        assign qual          = edge_qualifies(mode, ch_rise, ch_fall);
        assign ack_hit       = rd_ack && (rd_ch == 3'(g));
        assign capture_en[g] = cap_q;
        assign overrun[g]    = overrun_q;
        assign valid_vec[g]  = valid_q;
        assign result_arr[g] = result_q;

        // Channel state register.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state_q <= CH_IDLE;
            end else begin
                state_q <= state_d;
            end
        end

        // Next state; period_start always re-arms and masks a coincident edge.
        always_comb begin
            state_d = state_q;
            cap_d   = 1'b0;
            case (state_q)
                CH_IDLE: begin
                    if (period_start) state_d = CH_ARMED;
                end
                CH_ARMED: begin
                    if (period_start) begin
                        state_d = CH_ARMED;
                    end else if (qual) begin
                        state_d = CH_DONE;
                        cap_d   = 1'b1;
                    end
                end
                CH_DONE: begin
                    if (period_start) state_d = CH_ARMED;
                end
                default: state_d = CH_IDLE;
            endcase
        end

        // Capture result and flags; a capture wins over a coincident ack
        // but the ack still suppresses the overrun it would have caused.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                cap_q     <= 1'b0;
                result_q  <= '0;
                valid_q   <= 1'b0;
                overrun_q <= 1'b0;
            end else begin
                cap_q <= cap_d;
                if (cap_d) begin
                    result_q  <= pwm_count;
                    valid_q   <= 1'b1;
                    overrun_q <= ack_hit ? 1'b0 : (overrun_q | valid_q);
                end else if (ack_hit) begin
                    valid_q   <= 1'b0;
                    overrun_q <= 1'b0;
                end
            end
        end
    end

    // Readout mux; an out-of-range rd_ch matches no channel and reads zero.
    always_comb begin
        sample       = '0;
        sample_valid = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (rd_ch == 3'(i)) begin
                sample       = result_arr[i];
                sample_valid = valid_vec[i];
            end
        end
    end

    // Registered display of the selected sample or the test pattern.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led <= '0;
        end else begin
            led <= test_force ? LED_TEST_PATTERN : 16'(sample);
        end
    end

endmodule

// File: tb/tb_mc_comparator_capture.sv
// Bench for mc_comparator_capture: directed scenarios followed by random
// traffic, all compared every cycle against a window-based reference model.
module tb_mc_comparator_capture;

    localparam int N_CH  = 4;
    localparam int CNT_W = 8;
    localparam int S     = 2;
    localparam int F     = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [N_CH-1:0]  comp_in;
    logic [CNT_W-1:0] pwm_count;
    logic             period_start;
    logic [1:0]       edge_mode;
    logic [2:0]       rd_ch;
    logic             rd_ack;
    logic             test_force;
    logic [N_CH-1:0]  capture_en;
    logic [CNT_W-1:0] sample;
    logic             sample_valid;
    logic [N_CH-1:0]  overrun;
    logic [15:0]      led;

    mc_comparator_capture #(
        .N_CH        (N_CH),
        .CNT_W       (CNT_W),
        .SYNC_STAGES (S),
        .FILT_LEN    (F)
    ) u_dut (
        .clk          (clk),
        .reset        (reset),
        .comp_in      (comp_in),
        .pwm_count    (pwm_count),
        .period_start (period_start),
        .edge_mode    (edge_mode),
        .rd_ch        (rd_ch),
        .rd_ack       (rd_ack),
        .test_force   (test_force),
        .capture_en   (capture_en),
        .sample       (sample),
        .sample_valid (sample_valid),
        .overrun      (overrun),
        .led          (led)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // reference model state
    logic [3:0]  hist [$];
    logic [3:0]  m_level;
    logic [3:0]  m_armed;
    logic [3:0]  m_valid;
    logic [3:0]  m_ovr;
    logic [3:0]  m_cap;
    logic [7:0]  m_res [N_CH];
    logic [15:0] m_led;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] model_sample();
        if (int'(rd_ch) < N_CH) return m_res[int'(rd_ch)];
        return 8'h00;
    endfunction

    function automatic logic model_svalid();
        if (int'(rd_ch) < N_CH) return m_valid[int'(rd_ch)];
        return 1'b0;
    endfunction

    // Reset leaves the channel as if it had seen a long run of zeros.
    function automatic void model_reset();
        hist.delete();
        for (int i = 0; i < S + F; i++) hist.push_back(4'b0000);
        m_level = '0;
        m_armed = '0;
        m_valid = '0;
        m_ovr   = '0;
        m_cap   = '0;
        m_led   = '0;
        for (int i = 0; i < N_CH; i++) m_res[i] = '0;
    endfunction

    // One clock edge. A level is accepted once the F raw samples that have
    // cleared the S-stage synchroniser all agree and differ from the current
    // level; the capture decision for it lands S+F edges after the first
    // sample of that run.
    function automatic void model_edge();
        int d;
        hist.push_back(comp_in);
        d = hist.size() - 1;
        m_led = test_force ? 16'h5555 : {8'h00, model_sample()};
        for (int ch = 0; ch < N_CH; ch++) begin
            logic v, stable, rise, fall, qual, cap, ack;
            v      = hist[d-S-F][ch];
            stable = 1'b1;
            for (int k = d - S - F + 1; k <= d - S - 1; k++)
                if (hist[k][ch] != v) stable = 1'b0;
            rise = 1'b0;
            fall = 1'b0;
            if (stable && (v != m_level[ch])) begin
                m_level[ch] = v;
                rise = v;
                fall = ~v;
            end
            case (edge_mode)
                2'b00:   qual = rise;
                2'b01:   qual = fall;
                2'b10:   qual = rise | fall;
                default: qual = 1'b0;
            endcase
            cap = m_armed[ch] && qual && !period_start;
            ack = rd_ack && (int'(rd_ch) == ch);
            if (period_start) m_armed[ch] = 1'b1;
            else if (cap)     m_armed[ch] = 1'b0;
            if (cap) begin
                m_res[ch] = pwm_count;
                if (ack) m_ovr[ch] = 1'b0;
                else     m_ovr[ch] = m_ovr[ch] | m_valid[ch];
                m_valid[ch] = 1'b1;
            end else if (ack) begin
                m_valid[ch] = 1'b0;
                m_ovr[ch]   = 1'b0;
            end
            m_cap[ch] = cap;
        end
    endfunction

    task automatic check_all();
        check_val("cap_en",  32'(capture_en),   32'(m_cap));
        check_val("overrun", 32'(overrun),      32'(m_ovr));
        check_val("sample",  32'(sample),       32'(model_sample()));
        check_val("svalid",  32'(sample_valid), 32'(model_svalid()));
        check_val("led",     32'(led),          32'(m_led));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
        pwm_count = pwm_count + 8'd1;
    endtask

    task automatic pulse_period();
        period_start = 1'b1;
        step();
        period_start = 1'b0;
    endtask

    task automatic pulse_reset(input int edges);
        reset = 1'b1;
        model_reset();
        #1;
        check_all();
        repeat (edges) @(posedge clk);
        #1;
        check_all();
        reset = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, cnt;
        logic [7:0] p0;
        int hold [N_CH];
        int per_left;

        reset        = 1'b1;
        comp_in      = '0;
        pwm_count    = '0;
        period_start = 1'b0;
        edge_mode    = 2'b00;
        rd_ch        = 3'd0;
        rd_ack       = 1'b0;
        test_force   = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all();
        check_val("rst_led",    32'(led),        32'h0);
        check_val("rst_cap_en", 32'(capture_en), 32'h0);
        reset = 1'b0;

        // reset while ch0 is filtering; no period_start afterwards
        pulse_period();
        comp_in[0] = 1'b1;
        step();
        step();
        pulse_reset(2);
        cnt = 0;
        repeat (20) begin
            step();
            if (capture_en[0]) cnt++;
        end
        check_val("r35_nocap", 32'(cnt), 32'd0);
        check_val("r35_valid", 32'(sample_valid), 32'd0);
        check_val("r35_led",   32'(led), 32'd0);

        // clean rise on ch0: latency and captured count
        comp_in[0] = 1'b0;
        repeat (10) step();
        period_start = 1'b1;
        pwm_count    = 8'd0;
        step();
        period_start = 1'b0;
        comp_in[0]   = 1'b1;
        p0  = pwm_count;
        lat = -1;
        for (int i = 0; i < 20 && lat < 0; i++) begin
            step();
            if (capture_en[0]) lat = i;
        end
        check_val("r36_latency", 32'(lat), 32'(S + F));
        check_val("r36_sample",  32'(sample), 32'(8'(p0 + 8'(S + F))));
        check_val("r36_svalid",  32'(sample_valid), 32'd1);

        // 3-cycle glitch on ch2
        edge_mode  = 2'b10;
        comp_in[2] = 1'b1;
        repeat (3) step();
        comp_in[2] = 1'b0;
        cnt = 0;
        repeat (12) begin
            step();
            if (capture_en[2]) cnt++;
        end
        rd_ch = 3'd2;
        #1;
        check_val("r37_nocap",  32'(cnt), 32'd0);
        check_val("r37_svalid", 32'(sample_valid), 32'd0);

        // two rises on ch1 in one period, both-edge mode
        pulse_period();
        comp_in[1] = 1'b1;
        p0  = pwm_count;
        cnt = 0;
        repeat (8) begin step(); if (capture_en[1]) cnt++; end
        comp_in[1] = 1'b0;
        repeat (6) begin step(); if (capture_en[1]) cnt++; end
        comp_in[1] = 1'b1;
        repeat (10) begin step(); if (capture_en[1]) cnt++; end
        rd_ch = 3'd1;
        #1;
        check_val("r38_one_cap", 32'(cnt), 32'd1);
        check_val("r38_sample",  32'(sample), 32'(8'(p0 + 8'(S + F))));

        // ch3 captures in two periods without ack, then ack
        edge_mode = 2'b00;
        rd_ch     = 3'd3;
        pulse_period();
        comp_in[3] = 1'b1;
        repeat (10) step();
        comp_in[3] = 1'b0;
        repeat (8) step();
        pulse_period();
        comp_in[3] = 1'b1;
        p0 = pwm_count;
        repeat (10) step();
        check_val("r39_overrun", 32'(overrun[3]), 32'd1);
        check_val("r39_sample",  32'(sample), 32'(8'(p0 + 8'(S + F))));
        rd_ack = 1'b1;
        step();
        rd_ack = 1'b0;
        check_val("r39_ack_valid", 32'(sample_valid), 32'd0);
        check_val("r39_ack_ovr",   32'(overrun[3]),   32'd0);

        // qualified edge coincident with period_start is ignored
        rd_ch = 3'd0;
        pulse_period();
        comp_in[0] = 1'b0;
        repeat (10) step();
        comp_in[0] = 1'b1;
        repeat (S + F) step();
        period_start = 1'b1;
        step();
        period_start = 1'b0;
        check_val("r40_ignored", 32'(capture_en[0]), 32'd0);
        cnt = 0;
        repeat (10) begin step(); if (capture_en[0]) cnt++; end
        check_val("r40_nocap", 32'(cnt), 32'd0);
        test_force = 1'b1;
        step();
        check_val("r40_led_test", 32'(led), 32'h5555);
        test_force = 1'b0;
        step();

        // random traffic
        for (int c = 0; c < N_CH; c++) hold[c] = $urandom_range(1, 12);
        per_left = $urandom_range(8, 30);
        for (int n = 0; n < 2500; n++) begin
            for (int c = 0; c < N_CH; c++) begin
                hold[c]--;
                if (hold[c] == 0) begin
                    comp_in[c] = ~comp_in[c];
                    hold[c]    = $urandom_range(1, 12);
                end
            end
            period_start = 1'b0;
            per_left--;
            if (per_left == 0) begin
                period_start = 1'b1;
                pwm_count    = 8'd0;
                per_left     = $urandom_range(6, 30);
            end
            if ($urandom_range(0, 15) == 0) edge_mode = 2'($urandom_range(0, 3));
            rd_ch      = 3'($urandom_range(0, 5));
            rd_ack     = ($urandom_range(0, 5) == 0);
            test_force = ($urandom_range(0, 19) == 0);
            if (n == 1200) pulse_reset(2);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mc_comparator_capture.md
MC_COMPARATOR_CAPTURE -- requirements
Module: mc_comparator_capture

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of comparator channels, range 1..8.
REQ-002 SHALL have parameter CNT_W, default 8: PWM counter/sample width, range 4..16.
REQ-003 SHALL have parameter SYNC_STAGES, default 2: synchroniser flops per channel, minimum 2.
REQ-004 SHALL have parameter FILT_LEN, default 4: consecutive equal samples required to accept a level, range 1..16.
REQ-005 SHALL have port clk, input, 1: single clock, all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port comp_in, input, N_CH: raw asynchronous comparator outputs.
REQ-008 SHALL have port pwm_count, input, CNT_W: current PWM ramp value, clk-synchronous.
REQ-009 SHALL have port period_start, input, 1: one-cycle pulse marking PWM period start.
REQ-010 SHALL have port edge_mode, input, 2: qualified-edge select (rise/fall/both).
REQ-011 SHALL have port rd_ch, input, 3: channel selected for readout.
REQ-012 SHALL have port rd_ack, input, 1: acknowledge pulse for the selected channel.
REQ-013 SHALL have port test_force, input, 1: forces LED test pattern.
REQ-014 SHALL have port capture_en, output, N_CH: one-cycle per-channel capture pulse.
REQ-015 SHALL have port sample, output, CNT_W: stored result of rd_ch.
REQ-016 SHALL have port sample_valid, output, 1: valid flag of rd_ch.
REQ-017 SHALL have port overrun, output, N_CH: sticky per-channel overrun flags.
REQ-018 SHALL have port led, output, 16: display of sample or test pattern.

Function
REQ-019 Each channel SHALL synchronise comp_in through SYNC_STAGES flops, then accept a new filtered level only after FILT_LEN consecutive identical synchronised samples.
REQ-020 A qualified edge SHALL be a filtered-level change matching edge_mode: 00 rise, 01 fall, 10 both; 11 SHALL qualify no edge.
REQ-021 Latency from the first clk edge sampling a clean comp_in transition to the capture_en pulse SHALL be exactly SYNC_STAGES+FILT_LEN cycles.
REQ-022 Per-channel FSM states: CH_IDLE (after reset, no capture), CH_ARMED, CH_DONE.
REQ-023 CH_IDLE->CH_ARMED and CH_DONE->CH_ARMED SHALL occur on period_start; CH_ARMED->CH_DONE SHALL occur on a qualified edge.
REQ-024 A capture SHALL pulse capture_en[ch] for one cycle and write that cycle's pwm_count into result[ch].
REQ-025 Qualified edges in CH_IDLE or CH_DONE SHALL be ignored, so at most one capture per channel per period.
REQ-026 A qualified edge coincident with period_start SHALL be ignored; the channel enters CH_ARMED.
REQ-027 A capture SHALL set valid[ch]; if valid[ch] is already 1, it SHALL set overrun[ch] and overwrite result[ch].
REQ-028 rd_ack SHALL clear valid[rd_ch] and overrun[rd_ch]; if a capture on the same channel coincides, valid SHALL stay 1, overrun SHALL stay 0, and new data SHALL be stored.
REQ-029 sample and sample_valid SHALL be combinational from rd_ch; if rd_ch>=N_CH, they SHALL be 0 and rd_ack SHALL be ignored.
REQ-030 led SHALL be 16'h5555 while test_force=1, otherwise sample zero-extended to 16 bits, registered with one cycle latency.

Reset
REQ-031 Reset SHALL force CH_IDLE, zero filters and synchronisers, and set capture_en, result, valid, overrun and led to 0.
REQ-032 Reset asserted mid-period SHALL abort any capture; the first capture after release SHALL require a period_start.

Structure
REQ-033 Package mcc_pkg SHALL hold edge_mode_t (EDGE_RISE=00, EDGE_FALL=01, EDGE_BOTH=10, EDGE_NONE=11), ch_state_t, and LED_TEST_PATTERN=16'h5555.
REQ-034 Sub-module comp_chan_filter (synchroniser, filter, edge detect) SHALL be instantiated N_CH times via generate.

Verification (N_CH=4, CNT_W=8, SYNC_STAGES=2, FILT_LEN=4)
REQ-035 Reset during ch0 filtering, release, rise with no period_start -> no capture_en, valid=0, led=0.
REQ-036 period_start, ch0 clean rise in rise mode, pwm_count=cycle index -> capture_en[0] 6 cycles later, sample=captured count, sample_valid=1.
REQ-037 3-cycle glitch on ch2 -> no capture_en[2], valid[2]=0.
REQ-038 Two rises on ch1 in one period in both mode -> one capture; result holds the first edge's count.
REQ-039 Captures on ch3 in two periods without ack -> overrun[3]=1, result=second count; rd_ch=3 with rd_ack -> valid[3]=0, overrun[3]=0.
REQ-040 Edge filtered on period_start cycle -> ignored; test_force=1 -> led=16'h5555 next cycle.
